digit_serial_adder: RTL and testbench



---
 rtl/digit_serial_adder_if.sv | 32 +++
 rtl/digit_serial_adder.sv | 93 +++++++++
 tb/tb_digit_serial_adder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_adder_if.sv
// Operand, result and external-Adder signals of the digit-serial adder.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on operands, out_valid/out_ready on the result.
interface digit_serial_adder_if #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_lhs;
   logic [WIDTH-1:0] in_rhs;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             adder_cin;
   logic [DIGIT-1:0] adder_lhs;
   logic [DIGIT-1:0] adder_rhs;
   logic [DIGIT-1:0] adder_out;
   logic             adder_cout;

   modport slave (
      input  in_valid, in_lhs, in_rhs, in_cin, out_ready, adder_out, adder_cout,
      output in_ready, out_valid, out_sum, out_cout, adder_cin, adder_lhs, adder_rhs
   );

   modport master (
      output in_valid, in_lhs, in_rhs, in_cin, out_ready, adder_out, adder_cout,
      input  in_ready, out_valid, out_sum, out_cout, adder_cin, adder_lhs, adder_rhs
   );
endinterface

// File: rtl/digit_serial_adder.sv
// Sequences one WIDTH-bit add through an external DIGIT-bit Adder, LS digit first.
// Latency: out_valid from NDIG edges after the input handshake; one op in flight.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
module digit_serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic                clk,
   input  logic                reset,
   digit_serial_adder_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] lhs_sh;
   logic [WIDTH-1:0] rhs_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             run;

   // Result digits enter at the top and drift down, so the LS digit lands at bit 0.
   generate
      if (NDIG == 1) begin : g_one
         assign sum_nxt = bus.adder_out;
      end else begin : g_many
         assign sum_nxt = {bus.adder_out, sum_sh[WIDTH-1:DIGIT]};
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         lhs_sh      <= '0;
         rhs_sh      <= '0;
         sum_sh      <= '0;
         carry       <= 1'b0;
         cnt         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  lhs_sh     <= bus.in_lhs;
                  rhs_sh     <= bus.in_rhs;
                  carry      <= bus.in_cin;
                  cnt        <= '0;
                  sum_sh     <= '0;
                  in_ready_q <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               lhs_sh <= lhs_sh >> DIGIT;
               rhs_sh <= rhs_sh >> DIGIT;
               sum_sh <= sum_nxt;
               carry  <= bus.adder_cout;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // sum_sh and carry keep their final values in DONE; the mask zeroes them elsewhere.
   assign run           = (state == RUN);
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = sum_sh & {WIDTH{out_valid_q}};
   assign bus.out_cout  = carry & out_valid_q;
   assign bus.adder_lhs = run ? lhs_sh[DIGIT-1:0] : '0;
   assign bus.adder_rhs = run ? rhs_sh[DIGIT-1:0] : '0;
   assign bus.adder_cin = run & carry;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: transaction-level model plus directed and random traffic.
module tb_digit_serial_adder;
   localparam int W  = 8;
   localparam int D  = 2;
   localparam int N  = W / D;
   localparam int W2 = 2;
   localparam int D2 = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   digit_serial_adder_if #(.WIDTH(W),  .DIGIT(D))  bus  ();
   digit_serial_adder_if #(.WIDTH(W2), .DIGIT(D2)) bus2 ();

   digit_serial_adder #(.WIDTH(W),  .DIGIT(D))  dut  (.clk(clk), .reset(reset), .bus(bus));
   digit_serial_adder #(.WIDTH(W2), .DIGIT(D2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   // External combinational Adder stages
   assign {bus.adder_cout, bus.adder_out}   = bus.adder_lhs + bus.adder_rhs + bus.adder_cin;
   assign {bus2.adder_cout, bus2.adder_out} = bus2.adder_lhs + bus2.adder_rhs + bus2.adder_cin;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: busy flag plus cycles elapsed since the accepting edge.
   bit m_busy   = 1'b0;
   int m_rel    = 0;
   int m_lhs    = 0;
   int m_rhs    = 0;
   int m_cin    = 0;
   int m_exp    = 0;
   int done_cnt = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_rel  <= 0;
      end else if (!m_busy) begin
         if (bus.in_valid) begin
            m_busy <= 1'b1;
            m_rel  <= 0;
            m_lhs  <= int'(bus.in_lhs);
            m_rhs  <= int'(bus.in_rhs);
            m_cin  <= int'(bus.in_cin);
            m_exp  <= int'(bus.in_lhs) + int'(bus.in_rhs) + int'(bus.in_cin);
         end
      end else if (m_rel >= N && bus.out_ready) begin
         m_busy   <= 1'b0;
         done_cnt <= done_cnt + 1;
      end else if (m_rel < N) begin
         m_rel <= m_rel + 1;
      end
   end

   // Compare process: every output, every cycle, on the falling edge.
   initial begin
      int  e_rdy, e_vld, e_sum, e_cout, e_cin, e_l, e_r, lowm, sh;
      bit  run, done;
      forever begin
         @(negedge clk);
         run    = m_busy && (m_rel < N);
         done   = m_busy && (m_rel >= N);
         e_rdy  = m_busy ? 0 : 1;
         e_vld  = done ? 1 : 0;
         e_sum  = done ? (m_exp & ((1 << W) - 1)) : 0;
         e_cout = done ? ((m_exp >> W) & 1) : 0;
         e_cin  = 0;
         e_l    = 0;
         e_r    = 0;
         if (run) begin
            sh    = D * m_rel;
            lowm  = (1 << sh) - 1;
            e_l   = (m_lhs >> sh) & ((1 << D) - 1);
            e_r   = (m_rhs >> sh) & ((1 << D) - 1);
            e_cin = ((m_lhs & lowm) + (m_rhs & lowm) + m_cin) >> sh;
         end
         check("in_ready",  int'(bus.in_ready),  e_rdy);
         check("out_valid", int'(bus.out_valid), e_vld);
         check("out_sum",   int'(bus.out_sum),   e_sum);
         check("out_cout",  int'(bus.out_cout),  e_cout);
         check("adder_cin", int'(bus.adder_cin), e_cin);
         check("adder_lhs", int'(bus.adder_lhs), e_l);
         check("adder_rhs", int'(bus.adder_rhs), e_r);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start(input int l, input int r, input int c);
      bus.in_lhs   = W'(l);
      bus.in_rhs   = W'(r);
      bus.in_cin   = 1'(c);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         step();
         lat++;
      end
      check("out_valid timeout", int'(bus.out_valid), 1);
   endtask

   initial begin
      int lat;
      int target;
      int cyc;
      bus.in_valid  = 1'b0;
      bus.in_lhs    = '0;
      bus.in_rhs    = '0;
      bus.in_cin    = 1'b0;
      bus.out_ready = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_lhs    = '0;
      bus2.in_rhs    = '0;
      bus2.in_cin    = 1'b0;
      bus2.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      step();
      check("reset in_ready",  int'(bus.in_ready),  1);
      check("reset out_valid", int'(bus.out_valid), 0);
      check("reset out_sum",   int'(bus.out_sum),   0);
      check("reset adder_lhs", int'(bus.adder_lhs), 0);

      // Basic add: 1 + 3 + 1
      bus.out_ready = 1'b1;
      start(8'h01, 8'h03, 1);
      wait_valid(lat);
      check("basic latency", lat, 4);
      check("basic sum",  int'(bus.out_sum),  8'h05);
      check("basic cout", int'(bus.out_cout), 0);
      step();
      check("basic in_ready back", int'(bus.in_ready),  1);
      check("basic valid drop",    int'(bus.out_valid), 0);

      // Carry ripple
      start(8'hFF, 8'h01, 0);
      check("ripple cin run1", int'(bus.adder_cin), 0);
      for (int k = 2; k <= 4; k++) begin
         step();
         check("ripple cin run2-4", int'(bus.adder_cin), 1);
      end
      step();
      check("ripple valid", int'(bus.out_valid), 1);
      check("ripple sum",   int'(bus.out_sum),   8'h00);
      check("ripple cout",  int'(bus.out_cout),  1);
      step();
      start(8'hFF, 8'hFF, 1);
      wait_valid(lat);
      check("ff+ff+1 sum",  int'(bus.out_sum),  8'hFF);
      check("ff+ff+1 cout", int'(bus.out_cout), 1);
      step();

      // Backpressure with ignored in_valid pulses
      bus.out_ready = 1'b0;
      start(8'h5A, 8'h33, 0);
      wait_valid(lat);
      for (int k = 0; k < 6; k++) begin
         bus.in_valid = 1'(k % 2);
         bus.in_lhs   = W'($urandom());
         bus.in_rhs   = W'($urandom());
         step();
         check("bp sum",      int'(bus.out_sum),   8'h8D);
         check("bp cout",     int'(bus.out_cout),  0);
         check("bp in_ready", int'(bus.in_ready),  0);
         check("bp valid",    int'(bus.out_valid), 1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      check("bp release valid",    int'(bus.out_valid), 0);
      check("bp release in_ready", int'(bus.in_ready),  1);
      step();
      check("bp single transfer", int'(bus.out_valid), 0);

      // Reset in the second RUN cycle
      start(8'h77, 8'h11, 0);
      step();
      #1 reset = 1'b1;
      #1;
      check("arst in_ready",  int'(bus.in_ready),  1);
      check("arst out_valid", int'(bus.out_valid), 0);
      check("arst out_sum",   int'(bus.out_sum),   0);
      check("arst out_cout",  int'(bus.out_cout),  0);
      check("arst adder_cin", int'(bus.adder_cin), 0);
      check("arst adder_lhs", int'(bus.adder_lhs), 0);
      check("arst adder_rhs", int'(bus.adder_rhs), 0);
      @(posedge clk);
      #2 reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         check("arst no result", int'(bus.out_valid), 0);
      end
      start(8'h10, 8'h20, 0);
      wait_valid(lat);
      check("post-reset sum",  int'(bus.out_sum),  8'h30);
      check("post-reset cout", int'(bus.out_cout), 0);
      step();

      // Random traffic with stalls on both sides
      target = done_cnt + 500;
      cyc = 0;
      while (done_cnt < target && cyc < 20000) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_lhs    = W'($urandom());
         bus.in_rhs    = W'($urandom());
         bus.in_cin    = 1'($urandom());
         bus.out_ready = ($urandom_range(0, 2) != 0);
         step();
         cyc++;
      end
      check("random completions", done_cnt, target);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (N + 3) step();

      // Single-digit configuration: 1 + 3 + 1 over 2 bits
      check("ndig1 idle adder_lhs", int'(bus2.adder_lhs), 0);
      check("ndig1 idle in_ready",  int'(bus2.in_ready),  1);
      bus2.in_lhs   = 2'd1;
      bus2.in_rhs   = 2'd3;
      bus2.in_cin   = 1'b1;
      bus2.in_valid = 1'b1;
      step();
      bus2.in_valid = 1'b0;
      check("ndig1 run adder_lhs", int'(bus2.adder_lhs), 1);
      check("ndig1 run adder_rhs", int'(bus2.adder_rhs), 3);
      check("ndig1 run adder_cin", int'(bus2.adder_cin), 1);
      check("ndig1 run valid",     int'(bus2.out_valid), 0);
      check("ndig1 run in_ready",  int'(bus2.in_ready),  0);
      step();
      check("ndig1 valid", int'(bus2.out_valid), 1);
      check("ndig1 sum",   int'(bus2.out_sum),   1);
      check("ndig1 cout",  int'(bus2.out_cout),  1);
      check("ndig1 adder idle", int'(bus2.adder_lhs), 0);
      step();
      check("ndig1 done valid",    int'(bus2.out_valid), 0);
      check("ndig1 done in_ready", int'(bus2.in_ready),  1);
      check("ndig1 done sum",      int'(bus2.out_sum),   0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
